// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if -- bundle of the two requester ports, the SRAM port and
// the conflict counter of mem_port_arbiter.
//   slave  : arbiter side (takes requests and dout0, drives grants/SRAM/rdata)
//   master : requester/SRAM side (drives requests and dout0)
//   if_*   : instruction-fetch port (read-only)
//   d_*    : data port (read/write)
//   csb0/web0/addr0/din0/dout0 : single-port SRAM, active-low controls
//   conflict_cnt : saturating count of cycles with both requests high
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic              csb0;
    logic              web0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] din0;
    logic [DATA_W-1:0] dout0;

    logic [15:0]       conflict_cnt;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, dout0,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        output csb0, web0, addr0, din0, conflict_cnt
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, dout0,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        input  csb0, web0, addr0, din0, conflict_cnt
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter -- shares one single-port SRAM between an instruction-fetch
// port and a data port. Grants are combinational; simultaneous requests are
// resolved by a 1-bit round-robin pointer that moves to the loser. Read data
// returns one cycle after the grant, steered by per-port ownership tags.
//   clk   : clock, rising edge
//   reset : asynchronous, active-high
//   bus   : mem_port_arbiter_if.slave (requester ports, SRAM port, counter)
module mem_port_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_port_arbiter_if.slave    bus
);

    typedef enum logic {
        PRI_IF = 1'b0,
        PRI_D  = 1'b1
    } pri_e;

    pri_e        ptr_q, ptr_d;
    logic        if_tag_q, if_tag_d;
    logic        d_tag_q, d_tag_d;
    logic [15:0] cnt_q, cnt_d;

    logic              conflict;
    logic              d_win;
    logic              if_gnt;
    logic              d_gnt;
    logic              csb;
    logic              web;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;

    always_comb begin
        conflict = bus.if_req & bus.d_req;
        // Data wins when alone, or on a conflict when the pointer favours it.
        d_win    = bus.d_req & (~bus.if_req | (ptr_q == PRI_D));
        if_gnt   = bus.if_req & ~d_win;
        d_gnt    = d_win;

        csb  = 1'b1;
        web  = 1'b1;
        addr = '0;
        din  = '0;
        if (d_gnt) begin
            csb  = 1'b0;
            web  = ~bus.d_we;
            addr = bus.d_addr;
            din  = bus.d_wdata;
        end else if (if_gnt) begin
            csb  = 1'b0;
            addr = bus.if_addr;
        end

        ptr_d    = ptr_q;
        if (conflict) begin
            // Point at the loser so it wins the next conflict.
            ptr_d = (ptr_q == PRI_IF) ? PRI_D : PRI_IF;
        end
        if_tag_d = if_gnt;
        d_tag_d  = d_gnt & ~bus.d_we;
        cnt_d    = cnt_q;
        if (conflict && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q    <= PRI_IF;
            if_tag_q <= 1'b0;
            d_tag_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            ptr_q    <= ptr_d;
            if_tag_q <= if_tag_d;
            d_tag_q  <= d_tag_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.if_gnt       = if_gnt;
    assign bus.d_gnt        = d_gnt;
    assign bus.csb0         = csb;
    assign bus.web0         = web;
    assign bus.addr0        = addr;
    assign bus.din0         = din;
    assign bus.if_rvalid    = if_tag_q;
    assign bus.d_rvalid     = d_tag_q;
    assign bus.if_rdata     = if_tag_q ? bus.dout0 : '0;
    assign bus.d_rdata      = d_tag_q ? bus.dout0 : '0;
    assign bus.conflict_cnt = cnt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic clk;
    logic reset;

    mem_port_arbiter_if #(.ADDR_W(8), .DATA_W(32)) bus();

    mem_port_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        if_req;
        logic [7:0]  if_addr;
        logic        d_req;
        logic        d_we;
        logic [7:0]  d_addr;
        logic [31:0] d_wdata;
        logic [31:0] dout0;
        logic        e_if_gnt;
        logic        e_d_gnt;
        logic        e_csb0;
        logic        e_web0;
        logic [7:0]  e_addr0;
        logic [31:0] e_din0;
        logic        e_if_rv;
        logic        e_d_rv;
        logic [31:0] e_if_rd;
        logic [31:0] e_d_rd;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs[17];

    function automatic vec_t mkv(
        input logic ir, input logic [7:0] ia, input logic dr, input logic dw,
        input logic [7:0] da, input logic [31:0] dwd, input logic [31:0] dout,
        input logic eig, input logic edg, input logic ecs, input logic ewe,
        input logic [7:0] ead, input logic [31:0] edin,
        input logic eirv, input logic edrv, input logic [31:0] eird,
        input logic [31:0] edrd, input logic [15:0] ecnt);
        vec_t v;
        v.if_req = ir;  v.if_addr = ia;  v.d_req = dr;  v.d_we = dw;
        v.d_addr = da;  v.d_wdata = dwd; v.dout0 = dout;
        v.e_if_gnt = eig; v.e_d_gnt = edg; v.e_csb0 = ecs; v.e_web0 = ewe;
        v.e_addr0 = ead;  v.e_din0 = edin;
        v.e_if_rv = eirv; v.e_d_rv = edrv; v.e_if_rd = eird; v.e_d_rd = edrd;
        v.e_cnt = ecnt;
        return v;
    endfunction

    task automatic drive_idle(input logic [31:0] dout);
        bus.if_req  = 1'b0;
        bus.if_addr = '0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
        bus.dout0   = dout;
    endtask

    initial begin
        // inputs: ir ia dr dw da wdata dout | expected: ifg dg csb web addr0 din0 ifrv drv ifrd drd cnt
        vecs[0]  = mkv(0, 8'h00, 0, 0, 8'h00, 32'h0,        32'h0,        0, 0, 1, 1, 8'h00, 32'h0,        0, 0, 32'h0,        32'h0,  16'd0);
        vecs[1]  = mkv(1, 8'h10, 0, 0, 8'h00, 32'h0,        32'h0,        1, 0, 0, 1, 8'h10, 32'h0,        0, 0, 32'h0,        32'h0,  16'd0);
        vecs[2]  = mkv(0, 8'h00, 0, 0, 8'h00, 32'h0,        32'hCAFEF00D, 0, 0, 1, 1, 8'h00, 32'h0,        1, 0, 32'hCAFEF00D, 32'h0,  16'd0);
        vecs[3]  = mkv(0, 8'h00, 1, 1, 8'h05, 32'hDEADBEEF, 32'h11111111, 0, 1, 0, 0, 8'h05, 32'hDEADBEEF, 0, 0, 32'h0,        32'h0,  16'd0);
        vecs[4]  = mkv(0, 8'h00, 0, 0, 8'h00, 32'h0,        32'h22222222, 0, 0, 1, 1, 8'h00, 32'h0,        0, 0, 32'h0,        32'h0,  16'd0);
        vecs[5]  = mkv(1, 8'h30, 1, 0, 8'h20, 32'h12345678, 32'hA0,       1, 0, 0, 1, 8'h30, 32'h0,        0, 0, 32'h0,        32'h0,  16'd0);
        vecs[6]  = mkv(1, 8'h30, 1, 0, 8'h20, 32'h12345678, 32'hA1,       0, 1, 0, 1, 8'h20, 32'h12345678, 1, 0, 32'hA1,       32'h0,  16'd1);
        vecs[7]  = mkv(1, 8'h30, 1, 0, 8'h20, 32'h12345678, 32'hA2,       1, 0, 0, 1, 8'h30, 32'h0,        0, 1, 32'h0,        32'hA2, 16'd2);
        vecs[8]  = mkv(1, 8'h30, 1, 0, 8'h20, 32'h12345678, 32'hA3,       0, 1, 0, 1, 8'h20, 32'h12345678, 1, 0, 32'hA3,       32'h0,  16'd3);
        vecs[9]  = mkv(0, 8'h00, 1, 0, 8'h07, 32'h0,        32'hA4,       0, 1, 0, 1, 8'h07, 32'h0,        0, 1, 32'h0,        32'hA4, 16'd4);
        vecs[10] = mkv(1, 8'h3F, 0, 0, 8'h00, 32'h0,        32'hA5,       1, 0, 0, 1, 8'h3F, 32'h0,        0, 1, 32'h0,        32'hA5, 16'd4);
        vecs[11] = mkv(1, 8'h01, 1, 1, 8'h09, 32'h55AA55AA, 32'hA6,       1, 0, 0, 1, 8'h01, 32'h0,        1, 0, 32'hA6,       32'h0,  16'd4);
        vecs[12] = mkv(1, 8'h01, 1, 1, 8'h09, 32'h55AA55AA, 32'hA7,       0, 1, 0, 0, 8'h09, 32'h55AA55AA, 1, 0, 32'hA7,       32'h0,  16'd5);
        vecs[13] = mkv(0, 8'h00, 0, 0, 8'h00, 32'h0,        32'hA8,       0, 0, 1, 1, 8'h00, 32'h0,        0, 0, 32'h0,        32'h0,  16'd6);
        vecs[14] = mkv(0, 8'h00, 0, 0, 8'h00, 32'h0,        32'h0,        0, 0, 1, 1, 8'h00, 32'h0,        0, 0, 32'h0,        32'h0,  16'd6);
        vecs[15] = mkv(0, 8'h00, 0, 0, 8'h00, 32'h0,        32'h0,        0, 0, 1, 1, 8'h00, 32'h0,        0, 0, 32'h0,        32'h0,  16'd6);
        vecs[16] = mkv(1, 8'h02, 1, 0, 8'h04, 32'h0,        32'hB0,       1, 0, 0, 1, 8'h02, 32'h0,        0, 0, 32'h0,        32'h0,  16'd6);

        reset = 1'b1;
        drive_idle(32'h0);
        #2;
        chk("rst_if_rvalid", {31'b0, bus.if_rvalid}, 32'd0);
        chk("rst_d_rvalid", {31'b0, bus.d_rvalid}, 32'd0);
        chk("rst_cnt", {16'b0, bus.conflict_cnt}, 32'd0);
        chk("rst_csb0", {31'b0, bus.csb0}, 32'd1);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            bus.if_req  = vecs[i].if_req;
            bus.if_addr = vecs[i].if_addr;
            bus.d_req   = vecs[i].d_req;
            bus.d_we    = vecs[i].d_we;
            bus.d_addr  = vecs[i].d_addr;
            bus.d_wdata = vecs[i].d_wdata;
            bus.dout0   = vecs[i].dout0;
            #2;
            chk($sformatf("v%0d_if_gnt", i),    {31'b0, bus.if_gnt},    {31'b0, vecs[i].e_if_gnt});
            chk($sformatf("v%0d_d_gnt", i),     {31'b0, bus.d_gnt},     {31'b0, vecs[i].e_d_gnt});
            chk($sformatf("v%0d_csb0", i),      {31'b0, bus.csb0},      {31'b0, vecs[i].e_csb0});
            chk($sformatf("v%0d_web0", i),      {31'b0, bus.web0},      {31'b0, vecs[i].e_web0});
            chk($sformatf("v%0d_addr0", i),     {24'b0, bus.addr0},     {24'b0, vecs[i].e_addr0});
            chk($sformatf("v%0d_din0", i),      bus.din0,               vecs[i].e_din0);
            chk($sformatf("v%0d_if_rvalid", i), {31'b0, bus.if_rvalid}, {31'b0, vecs[i].e_if_rv});
            chk($sformatf("v%0d_d_rvalid", i),  {31'b0, bus.d_rvalid},  {31'b0, vecs[i].e_d_rv});
            chk($sformatf("v%0d_if_rdata", i),  bus.if_rdata,           vecs[i].e_if_rd);
            chk($sformatf("v%0d_d_rdata", i),   bus.d_rdata,            vecs[i].e_d_rd);
            chk($sformatf("v%0d_cnt", i),       {16'b0, bus.conflict_cnt}, {16'b0, vecs[i].e_cnt});
        end

        // Fetch read granted in the last vector; reset lands mid-return cycle.
        @(negedge clk);
        drive_idle(32'hC0);
        #2;
        chk("pre_rst_if_rvalid", {31'b0, bus.if_rvalid}, 32'd1);
        chk("pre_rst_if_rdata", bus.if_rdata, 32'hC0);
        chk("pre_rst_cnt", {16'b0, bus.conflict_cnt}, 32'd7);
        reset = 1'b1;
        #1;
        chk("mid_rst_if_rvalid", {31'b0, bus.if_rvalid}, 32'd0);
        chk("mid_rst_if_rdata", bus.if_rdata, 32'd0);
        chk("mid_rst_d_rvalid", {31'b0, bus.d_rvalid}, 32'd0);
        chk("mid_rst_cnt", {16'b0, bus.conflict_cnt}, 32'd0);
        bus.if_req  = 1'b1;
        bus.if_addr = 8'h44;
        #1;
        chk("in_rst_if_gnt", {31'b0, bus.if_gnt}, 32'd1);
        chk("in_rst_csb0", {31'b0, bus.csb0}, 32'd0);
        chk("in_rst_addr0", {24'b0, bus.addr0}, 32'h44);

        // Read granted while reset is held must not return data.
        @(negedge clk);
        drive_idle(32'hC1);
        #2;
        chk("held_rst_if_rvalid", {31'b0, bus.if_rvalid}, 32'd0);
        reset = 1'b0;

        // Pointer was at data before reset; first conflict after release goes to fetch.
        bus.if_req  = 1'b1;
        bus.if_addr = 8'h50;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b0;
        bus.d_addr  = 8'h60;
        #1;
        chk("post_rst_if_gnt", {31'b0, bus.if_gnt}, 32'd1);
        chk("post_rst_d_gnt", {31'b0, bus.d_gnt}, 32'd0);
        chk("post_rst_addr0", {24'b0, bus.addr0}, 32'h50);

        // Hold the conflict until the counter reaches its ceiling.
        repeat (65534) @(posedge clk);
        @(negedge clk);
        #2;
        chk("sat_cnt_fffe", {16'b0, bus.conflict_cnt}, 32'hFFFE);
        chk("sat_alt_if_gnt", {31'b0, bus.if_gnt}, 32'd1);
        @(negedge clk);
        #2;
        chk("sat_cnt_ffff", {16'b0, bus.conflict_cnt}, 32'hFFFF);
        chk("sat_alt_d_gnt", {31'b0, bus.d_gnt}, 32'd1);
        @(negedge clk);
        #2;
        chk("sat_cnt_hold", {16'b0, bus.conflict_cnt}, 32'hFFFF);
        @(negedge clk);
        #2;
        chk("sat_cnt_hold2", {16'b0, bus.conflict_cnt}, 32'hFFFF);

        drive_idle(32'h0);
        #1;
        chk("end_csb0", {31'b0, bus.csb0}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
